uart_tx_oversampled: RTL and testbench

UART transmitter that runs on the same oversampling clock as the receive path and uses the same 5-bit Prescale encoding, so both directions of one link share a single clock and a single Prescale setting. It accepts an 8-bit parallel word with a one-cycle valid strobe. It then serialises the word as start bit, 8 data bits LSB first, optional parity and stop bit, holding each bit for exactly Prescale clock cycles. An internal FSM, a Prescale-cycle edge counter and a bit counter sequence the frame.

---
 rtl/uart_tx_oversampled.sv | 150 +++++++++++++++
 tb/tb_uart_tx_oversampled.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_oversampled.sv
// uart_tx_oversampled
//
// UART transmitter clocked by the oversampling clock (baud x Prescale), sharing
// the receive path's 5-bit Prescale encoding. A word presented with a one-cycle
// Data_Valid strobe while idle is framed as start, 8 data bits LSB first,
// optional parity and one stop bit, each held for P = max(Prescale, 4) cycles.
//
// Ports:
//   CLK         oversampling clock, rising edge
//   RST         asynchronous active-high reset
//   P_DATA      word to transmit, sampled on the accept edge
//   Data_Valid  request strobe, honoured only while Busy = 0
//   PAR_EN      1 = insert parity bit after the data
//   PAR_TYP     0 = even parity, 1 = odd parity
//   Prescale    clock cycles per bit (0..3 treated as 4)
//   TX_OUT      registered serial line, idle high
//   Busy        registered, high from accept edge to end of stop bit

module uart_tx_oversampled (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] P_DATA,
    input  logic       Data_Valid,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    input  logic [4:0] Prescale,
    output logic       TX_OUT,
    output logic       Busy
);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e     state_q, state_d;
    logic [4:0] edge_cnt_q, edge_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] data_q, data_d;
    logic [4:0] presc_q, presc_d;
    logic       par_en_q, par_en_d;
    logic       par_bit_q, par_bit_d;
    logic       tx_q, tx_d;
    logic       busy_q, busy_d;

    logic [4:0] presc_eff;
    logic       bit_end;

    assign presc_eff = (Prescale < 5'd4) ? 5'd4 : Prescale;
    // Last cycle of the current bit; the transition edge loads the next level.
    assign bit_end   = (edge_cnt_q == presc_q - 5'd1);

    always_comb begin
        state_d    = state_q;
        edge_cnt_d = bit_end ? 5'd0 : edge_cnt_q + 5'd1;
        bit_cnt_d  = bit_cnt_q;
        data_d     = data_q;
        presc_d    = presc_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        tx_d       = tx_q;
        busy_d     = busy_q;

        unique case (state_q)
            StIdle: begin
                edge_cnt_d = 5'd0;
                bit_cnt_d  = 3'd0;
                tx_d       = 1'b1;
                busy_d     = 1'b0;
                if (Data_Valid) begin
                    data_d    = P_DATA;
                    presc_d   = presc_eff;
                    par_en_d  = PAR_EN;
                    par_bit_d = (^P_DATA) ^ PAR_TYP;
                    state_d   = StStart;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d   = StData;
                    bit_cnt_d = 3'd0;
                    tx_d      = data_q[0];
                end
            end
            StData: begin
                if (bit_end) begin
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = 3'd0;
                        if (par_en_q) begin
                            state_d = StParity;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = StStop;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_d      = data_q[bit_cnt_q + 3'd1];
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    tx_d    = 1'b1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    state_d = StIdle;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d    = StIdle;
                edge_cnt_d = 5'd0;
                tx_d       = 1'b1;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StIdle;
            edge_cnt_q <= 5'd0;
            bit_cnt_q  <= 3'd0;
            data_q     <= 8'd0;
            presc_q    <= 5'd4;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            data_q     <= data_d;
            presc_q    <= presc_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_oversampled.sv
// Directed testbench for uart_tx_oversampled. Inputs change on the falling edge,
// outputs are sampled on the falling edge, clear of the active rising edge.

module tb_uart_tx_oversampled;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [4:0] Prescale;
    logic       TX_OUT;
    logic       Busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic tx_log   [400];
    logic busy_log [400];

    uart_tx_oversampled dut (
        .CLK       (CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .Data_Valid(Data_Valid),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .Prescale  (Prescale),
        .TX_OUT    (TX_OUT),
        .Busy      (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Expected line level k cycles after the accept edge for a single frame.
    function automatic logic exp_tx(input logic [7:0] d, input logic pe, input logic pt,
                                    input int p, input int k);
        int idx;
        idx = k / p;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (pe && idx == 9) return (^d) ^ pt;
        return 1'b1;
    endfunction

    function automatic logic exp_busy(input logic pe, input int p, input int k);
        return k < (10 + (pe ? 1 : 0)) * p;
    endfunction

    task automatic reset_dut();
        Data_Valid = 1'b0;
        RST        = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // Presents a request and records ncyc samples, sample k taken k+1 edges after
    // the request is presented (k = 0 is the cycle right after the accept edge).
    task automatic run_log(input logic [7:0] d, input logic pe, input logic pt,
                           input logic [4:0] ps, input int ncyc, input bit hold,
                           input bit disturb);
        @(negedge CLK);
        P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Prescale = ps; Data_Valid = 1'b1;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge CLK);
            tx_log[k]   = TX_OUT;
            busy_log[k] = Busy;
            Data_Valid  = hold;
            if (disturb && k == 20) begin
                Data_Valid = 1'b1;
                P_DATA     = 8'h3C;
                Prescale   = 5'd16;
                PAR_EN     = ~pe;
                PAR_TYP    = ~pt;
            end
        end
        Data_Valid = 1'b0;
    endtask

    task automatic test_reset();
        Data_Valid = 1'b0; P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 5'd8;
        RST = 1'b0;
        #1 RST = 1'b1;
        #1;
        n_checks++;
        if (TX_OUT !== 1'b1) begin
            n_fail++; $display("FAIL reset_tx got %b want 1", TX_OUT);
        end
        n_checks++;
        if (Busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy got %b want 0", Busy);
        end
        @(negedge CLK);
        @(negedge CLK);
        n_checks++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_clocked got tx=%b busy=%b want tx=1 busy=0", TX_OUT, Busy);
        end
        RST = 1'b0;
    endtask

    task automatic test_even_parity();
        logic [10:0] exp_bits;
        int busy_cnt;
        reset_dut();
        run_log(8'hA5, 1'b1, 1'b0, 5'd8, 96, 1'b0, 1'b0);
        exp_bits = 11'b1_0_1010_0101_0;  // index 0 = start bit
        busy_cnt = 0;
        for (int k = 0; k < 96; k++) begin
            logic e;
            e = (k < 88) ? exp_bits[k/8] : 1'b1;
            n_checks++;
            if (tx_log[k] !== e) begin
                n_fail++; $display("FAIL even_tx k=%0d got %b want %b", k, tx_log[k], e);
            end
            if (busy_log[k] === 1'b1) busy_cnt++;
        end
        n_checks++;
        if (busy_cnt != 88) begin
            n_fail++; $display("FAIL even_busy_len got %0d want 88", busy_cnt);
        end
        n_checks++;
        if (busy_log[87] !== 1'b1 || busy_log[88] !== 1'b0) begin
            n_fail++; $display("FAIL even_busy_edge got %b%b want 10", busy_log[87], busy_log[88]);
        end
    endtask

    task automatic test_odd_zero();
        int busy_cnt;
        reset_dut();
        run_log(8'h00, 1'b1, 1'b1, 5'd16, 190, 1'b0, 1'b0);
        busy_cnt = 0;
        for (int k = 0; k < 190; k++) begin
            n_checks++;
            if (tx_log[k] !== exp_tx(8'h00, 1'b1, 1'b1, 16, k)) begin
                n_fail++; $display("FAIL odd_tx k=%0d got %b want %b", k, tx_log[k],
                                   exp_tx(8'h00, 1'b1, 1'b1, 16, k));
            end
            if (busy_log[k] === 1'b1) busy_cnt++;
        end
        n_checks++;
        if (tx_log[9*16+8] !== 1'b1) begin
            n_fail++; $display("FAIL odd_parity_bit got %b want 1", tx_log[9*16+8]);
        end
        n_checks++;
        if (busy_cnt != 176) begin
            n_fail++; $display("FAIL odd_busy_len got %0d want 176", busy_cnt);
        end
    endtask

    task automatic test_no_parity();
        int busy_cnt;
        reset_dut();
        run_log(8'hFF, 1'b0, 1'b0, 5'd16, 170, 1'b0, 1'b0);
        busy_cnt = 0;
        for (int k = 0; k < 170; k++) begin
            logic e;
            e = (k < 16) ? 1'b0 : 1'b1;
            n_checks++;
            if (tx_log[k] !== e) begin
                n_fail++; $display("FAIL nopar_tx k=%0d got %b want %b", k, tx_log[k], e);
            end
            if (busy_log[k] === 1'b1) busy_cnt++;
        end
        n_checks++;
        if (busy_cnt != 160) begin
            n_fail++; $display("FAIL nopar_busy_len got %0d want 160", busy_cnt);
        end
    endtask

    task automatic test_midframe_changes();
        reset_dut();
        run_log(8'h96, 1'b1, 1'b0, 5'd8, 130, 1'b0, 1'b1);
        for (int k = 0; k < 130; k++) begin
            n_checks++;
            if (tx_log[k] !== exp_tx(8'h96, 1'b1, 1'b0, 8, k) ||
                busy_log[k] !== exp_busy(1'b1, 8, k)) begin
                n_fail++; $display("FAIL midframe k=%0d got tx=%b busy=%b want tx=%b busy=%b",
                                   k, tx_log[k], busy_log[k], exp_tx(8'h96, 1'b1, 1'b0, 8, k),
                                   exp_busy(1'b1, 8, k));
            end
        end
    endtask

    task automatic test_back_to_back();
        reset_dut();
        run_log(8'h55, 1'b0, 1'b0, 5'd8, 170, 1'b1, 1'b0);
        for (int k = 0; k < 170; k++) begin
            int  kk;
            logic et, eb;
            kk = k % 81;
            et = (kk == 80) ? 1'b1 : exp_tx(8'h55, 1'b0, 1'b0, 8, kk);
            eb = (kk != 80);
            n_checks++;
            if (tx_log[k] !== et || busy_log[k] !== eb) begin
                n_fail++; $display("FAIL b2b k=%0d got tx=%b busy=%b want tx=%b busy=%b",
                                   k, tx_log[k], busy_log[k], et, eb);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int busy_cnt;
        reset_dut();
        @(negedge CLK);
        P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b0; Prescale = 5'd8; Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        repeat (35) @(negedge CLK);
        // Now in data bit 3 of 0xA5, which is a 0.
        n_checks++;
        if (TX_OUT !== 1'b0 || Busy !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset got tx=%b busy=%b want tx=0 busy=1", TX_OUT, Busy);
        end
        #2 RST = 1'b1;
        #1;
        n_checks++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            n_fail++; $display("FAIL async_reset got tx=%b busy=%b want tx=1 busy=0", TX_OUT, Busy);
        end
        @(negedge CLK);
        RST = 1'b0;
        run_log(8'h5A, 1'b1, 1'b1, 5'd2, 50, 1'b0, 1'b0);
        busy_cnt = 0;
        for (int k = 0; k < 50; k++) begin
            n_checks++;
            if (tx_log[k] !== exp_tx(8'h5A, 1'b1, 1'b1, 4, k)) begin
                n_fail++; $display("FAIL clamp_tx k=%0d got %b want %b", k, tx_log[k],
                                   exp_tx(8'h5A, 1'b1, 1'b1, 4, k));
            end
            if (busy_log[k] === 1'b1) busy_cnt++;
        end
        n_checks++;
        if (busy_cnt != 44) begin
            n_fail++; $display("FAIL clamp_busy_len got %0d want 44", busy_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_even_parity();
        test_odd_zero();
        test_no_parity();
        test_midframe_changes();
        test_back_to_back();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
